// File: rtl/psg_pkg.sv
// psg_pkg: shared constants and byte encoders for the PSG command writer.
//   - FSM state codes (IDLE, LATCH, GAP_A, DATA, GAP_B)
//   - Opcode constants for the SN76489 latch/data byte protocol
//   - encode_latch(): builds the first (latch) byte of any command
//   - encode_data(): builds the second (data) byte of a tone frequency write
package psg_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_GAP_A = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_GAP_B = 3'd4;

  localparam logic [7:0] LATCH_BIT = 8'h80;
  localparam logic [1:0] NOISE_CH  = 2'd3;

  // FIFO entry layout: {ch[1:0], atten, data[9:0]}
  localparam int CMD_W = 13;

  // Latch byte: {1, ch, type, payload}. Noise control reuses the ch3 latch with
  // type=0 and only a 3-bit payload {fb, nf[1:0]}.
  function automatic logic [7:0] encode_latch(input logic [1:0] ch,
                                              input logic       atten,
                                              input logic [3:0] data);
    if (atten)
      return LATCH_BIT | {1'b0, ch, 1'b1, data};
    else if (ch == NOISE_CH)
      return LATCH_BIT | {1'b0, ch, 2'b00, data[2:0]};
    else
      return LATCH_BIT | {1'b0, ch, 1'b0, data};
  endfunction

  function automatic logic [7:0] encode_data(input logic [5:0] hi);
    return {2'b00, hi};
  endfunction

endpackage

// File: rtl/psg_cmd_fifo.sv
// psg_cmd_fifo: small synchronous FIFO holding pending PSG commands.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (pointers only)
//   push, din       write request / entry (ignored when full)
//   pop             read request (ignored when empty)
//   dout            head entry, valid while !empty
//   full, empty     occupancy flags
module psg_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/psg_cmd_writer.sv
// psg_cmd_writer: buffers high-level PSG commands and serialises them into the
// SN76489 latch/data byte protocol, with a programmable idle gap between strobes.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (ready = FIFO not full)
//   cmd_ch, cmd_atten, cmd_data  channel, attenuation select, payload
//   psg_wrdata, psg_wren       registered byte and one-cycle strobe to the psg
//   idle                       FIFO empty and FSM in IDLE
//
// state  | meaning
// IDLE   | waiting for a queued command; pops and emits the latch byte
// LATCH  | latch byte strobe cycle; loads gap counter
// GAP_A  | wren-low gap after latch byte; decides whether a data byte follows
// DATA   | data byte strobe cycle; loads gap counter
// GAP_B  | wren-low gap after data byte
module psg_cmd_writer
  import psg_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 32,
  parameter int SKIP_REDUNDANT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_ch,
  input  logic       cmd_atten,
  input  logic [9:0] cmd_data,
  output logic [7:0] psg_wrdata,
  output logic       psg_wren,
  output logic       idle
);

  localparam int            GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  logic [CMD_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  logic [2:0]    state;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    cur_ch;
  logic          cur_atten;
  logic [5:0]    cur_hi;
  logic [5:0]    shadow_hi [3];
  logic [2:0]    shadow_valid;

  logic is_freq;
  logic redundant;

  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign idle      = fifo_empty && (state == ST_IDLE);

  psg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .din   ({cmd_ch, cmd_atten, cmd_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Only tone frequency writes carry a data byte; it may be dropped when the
  // psg already holds the same upper divider bits for that channel.
  assign is_freq   = !cur_atten && (cur_ch != NOISE_CH);
  assign redundant = (SKIP_REDUNDANT != 0) && shadow_valid[cur_ch] &&
                     (shadow_hi[cur_ch] == cur_hi);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      gap_cnt      <= '0;
      cur_ch       <= '0;
      cur_atten    <= 1'b0;
      cur_hi       <= '0;
      psg_wrdata   <= 8'h00;
      psg_wren     <= 1'b0;
      shadow_valid <= '0;
      for (int i = 0; i < 3; i++) shadow_hi[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_ch     <= fifo_dout[12:11];
            cur_atten  <= fifo_dout[10];
            cur_hi     <= fifo_dout[9:4];
            psg_wrdata <= encode_latch(fifo_dout[12:11], fifo_dout[10], fifo_dout[3:0]);
            psg_wren   <= 1'b1;
            state      <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          psg_wren <= 1'b0;
          gap_cnt  <= GAP_LOAD;
          state    <= ST_GAP_A;
        end
        ST_GAP_A: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if (is_freq && !redundant) begin
            psg_wrdata           <= encode_data(cur_hi);
            psg_wren             <= 1'b1;
            shadow_hi[cur_ch]    <= cur_hi;
            shadow_valid[cur_ch] <= 1'b1;
            state                <= ST_DATA;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          psg_wren <= 1'b0;
          gap_cnt  <= GAP_LOAD;
          state    <= ST_GAP_B;
        end
        ST_GAP_B: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
          else               state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_cmd_writer.sv
// Testbench for psg_cmd_writer: dut_a uses default parameters, dut_b enables
// redundant data-byte skipping. Each scenario task drives commands and checks
// the captured byte stream against hand-computed PSG bytes.
module tb_psg_cmd_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [1:0] ch_a = '0, ch_b = '0;
  logic       atten_a = 1'b0, atten_b = 1'b0;
  logic [9:0] data_a = '0, data_b = '0;
  logic       ready_a, ready_b;
  logic [7:0] wrdata_a, wrdata_b;
  logic       wren_a, wren_b;
  logic       idle_a, idle_b;

  int checks = 0;
  int failures = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int  low_a = 0, low_b = 0;
  int  min_gap_a = 1000, min_gap_b = 1000;
  bit  seen_a = 0, seen_b = 0;

  always #5 clk = ~clk;

  psg_cmd_writer dut_a (
    .clk(clk), .reset(reset), .cmd_valid(valid_a), .cmd_ready(ready_a),
    .cmd_ch(ch_a), .cmd_atten(atten_a), .cmd_data(data_a),
    .psg_wrdata(wrdata_a), .psg_wren(wren_a), .idle(idle_a)
  );

  psg_cmd_writer #(.FIFO_DEPTH(4), .GAP_CYCLES(32), .SKIP_REDUNDANT(1)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_ch(ch_b), .cmd_atten(atten_b), .cmd_data(data_b),
    .psg_wrdata(wrdata_b), .psg_wren(wren_b), .idle(idle_b)
  );

  // Byte capture and wren-low gap measurement, sampled on the falling edge.
  always @(negedge clk) begin
    if (wren_a) begin
      q_a.push_back(wrdata_a);
      if (seen_a && low_a < min_gap_a) min_gap_a = low_a;
      seen_a = 1; low_a = 0;
    end else low_a++;
    if (wren_b) begin
      q_b.push_back(wrdata_b);
      if (seen_b && low_b < min_gap_b) min_gap_b = low_b;
      seen_b = 1; low_b = 0;
    end else low_b++;
  end

  task automatic clear_mon();
    q_a.delete(); q_b.delete();
    seen_a = 0; seen_b = 0;
    min_gap_a = 1000; min_gap_b = 1000;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input int d, input logic [1:0] ch, input logic atten, input logic [9:0] data);
    int n = 0;
    @(negedge clk);
    if (d == 0) begin valid_a = 1; ch_a = ch; atten_a = atten; data_a = data; end
    else        begin valid_b = 1; ch_b = ch; atten_b = atten; data_b = data; end
    while (!(d == 0 ? ready_a : ready_b) && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (n >= 500) begin failures++; $display("FAIL send_timeout dut=%0d waited=%0d limit=500", d, n); end
    @(negedge clk);
    valid_a = 0; valid_b = 0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while (!(d == 0 ? idle_a : idle_b) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 3000) begin failures++; $display("FAIL idle_timeout dut=%0d waited=%0d limit=3000", d, n); end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (wren_a !== 1'b0)    begin failures++; $display("FAIL rst_wren_a got=%b exp=0", wren_a); end
    checks++; if (wrdata_a !== 8'h00) begin failures++; $display("FAIL rst_wrdata_a got=%h exp=00", wrdata_a); end
    checks++; if (ready_a !== 1'b1)   begin failures++; $display("FAIL rst_ready_a got=%b exp=1", ready_a); end
    checks++; if (idle_a !== 1'b1)    begin failures++; $display("FAIL rst_idle_a got=%b exp=1", idle_a); end
    checks++; if (wren_b !== 1'b0)    begin failures++; $display("FAIL rst_wren_b got=%b exp=0", wren_b); end
    checks++; if (idle_b !== 1'b1)    begin failures++; $display("FAIL rst_idle_b got=%b exp=1", idle_b); end
  endtask

  task automatic test_freq();
    logic [7:0] exp [2] = '{8'h85, 8'h2A};
    clear_mon();
    send(0, 2'd0, 1'b0, 10'h2A5);
    checks++; if (wren_a !== 1'b0) begin failures++; $display("FAIL freq_lat_early got=%b exp=0", wren_a); end
    @(negedge clk);
    checks++; if (wren_a !== 1'b1 || wrdata_a !== 8'h85)
      begin failures++; $display("FAIL freq_lat wren=%b data=%h exp wren=1 data=85", wren_a, wrdata_a); end
    wait_idle(0);
    checks++; if (q_a.size() != 2) begin failures++; $display("FAIL freq_count got=%0d exp=2", q_a.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= q_a.size() || q_a[i] !== exp[i])
        begin failures++; $display("FAIL freq_byte%0d got=%h exp=%h", i, (i < q_a.size()) ? q_a[i] : 8'hxx, exp[i]); end
    end
    checks++; if (min_gap_a < 32) begin failures++; $display("FAIL freq_gap got=%0d exp>=32", min_gap_a); end
  endtask

  task automatic test_atten();
    logic [7:0] exp [2] = '{8'hD7, 8'hFF};
    clear_mon();
    send(0, 2'd2, 1'b1, 10'h007);
    send(0, 2'd3, 1'b1, 10'h00F);
    wait_idle(0);
    checks++; if (q_a.size() != 2) begin failures++; $display("FAIL atten_count got=%0d exp=2", q_a.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= q_a.size() || q_a[i] !== exp[i])
        begin failures++; $display("FAIL atten_byte%0d got=%h exp=%h", i, (i < q_a.size()) ? q_a[i] : 8'hxx, exp[i]); end
    end
    checks++; if (min_gap_a < 32) begin failures++; $display("FAIL atten_gap got=%0d exp>=32", min_gap_a); end
    checks++; if (idle_a !== 1'b1) begin failures++; $display("FAIL atten_idle got=%b exp=1", idle_a); end
  endtask

  task automatic test_noise();
    clear_mon();
    send(0, 2'd3, 1'b0, 10'h3FD);  // upper bits set but must be ignored
    wait_idle(0);
    checks++; if (q_a.size() != 1) begin failures++; $display("FAIL noise_count got=%0d exp=1", q_a.size()); end
    checks++; if (q_a.size() < 1 || q_a[0] !== 8'hE5)
      begin failures++; $display("FAIL noise_byte got=%h exp=e5", (q_a.size() > 0) ? q_a[0] : 8'hxx); end
  endtask

  task automatic test_skip();
    logic [7:0] exp_b [3] = '{8'hA3, 8'h12, 8'hA3};
    logic [7:0] exp_a [4] = '{8'hA3, 8'h12, 8'hA3, 8'h12};
    clear_mon();
    send(1, 2'd1, 1'b0, 10'h123); wait_idle(1);
    send(1, 2'd1, 1'b0, 10'h123); wait_idle(1);
    send(0, 2'd1, 1'b0, 10'h123); wait_idle(0);
    send(0, 2'd1, 1'b0, 10'h123); wait_idle(0);
    checks++; if (q_b.size() != 3) begin failures++; $display("FAIL skip_count got=%0d exp=3", q_b.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= q_b.size() || q_b[i] !== exp_b[i])
        begin failures++; $display("FAIL skip_byte%0d got=%h exp=%h", i, (i < q_b.size()) ? q_b[i] : 8'hxx, exp_b[i]); end
    end
    checks++; if (q_a.size() != 4) begin failures++; $display("FAIL noskip_count got=%0d exp=4", q_a.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_a.size() || q_a[i] !== exp_a[i])
        begin failures++; $display("FAIL noskip_byte%0d got=%h exp=%h", i, (i < q_a.size()) ? q_a[i] : 8'hxx, exp_a[i]); end
    end
    apply_reset();
    clear_mon();
    send(1, 2'd1, 1'b0, 10'h123); wait_idle(1);
    checks++; if (q_b.size() != 2) begin failures++; $display("FAIL skip_rst_count got=%0d exp=2", q_b.size()); end
    checks++; if (q_b.size() < 2 || q_b[0] !== 8'hA3 || q_b[1] !== 8'h12)
      begin failures++; $display("FAIL skip_rst_bytes got=%h,%h exp=a3,12",
        (q_b.size() > 0) ? q_b[0] : 8'hxx, (q_b.size() > 1) ? q_b[1] : 8'hxx); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] cmds [6] = '{{2'd0, 1'b0, 10'h2A5}, {2'd1, 1'b1, 10'h003}, {2'd3, 1'b0, 10'h006},
                              {2'd2, 1'b0, 10'h3FF}, {2'd0, 1'b1, 10'h000}, {2'd1, 1'b0, 10'h001}};
    logic [7:0] exp [9] = '{8'h85, 8'h2A, 8'hB3, 8'hE6, 8'hCF, 8'h3F, 8'h90, 8'hA1, 8'h00};
    bit saw_full = 0;
    int n;
    clear_mon();
    @(negedge clk);
    valid_a = 1;
    for (int i = 0; i < 6; i++) begin
      {ch_a, atten_a, data_a} = cmds[i];
      n = 0;
      while (!ready_a && n < 500) begin saw_full = 1; @(negedge clk); n++; end
      checks++;
      if (n >= 500) begin failures++; $display("FAIL burst_ready_timeout cmd=%0d waited=%0d limit=500", i, n); end
      @(negedge clk);
    end
    valid_a = 0;
    checks++; if (!saw_full) begin failures++; $display("FAIL burst_ready_drop got=never_low exp=low_when_full"); end
    wait_idle(0);
    checks++; if (q_a.size() != 9) begin failures++; $display("FAIL burst_count got=%0d exp=9", q_a.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= q_a.size() || q_a[i] !== exp[i])
        begin failures++; $display("FAIL burst_byte%0d got=%h exp=%h", i, (i < q_a.size()) ? q_a[i] : 8'hxx, exp[i]); end
    end
    checks++; if (min_gap_a < 32) begin failures++; $display("FAIL burst_gap got=%0d exp>=32", min_gap_a); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_mon();
    send(0, 2'd0, 1'b0, 10'h2A5);
    while (q_a.size() == 0 && n < 200) begin @(negedge clk); n++; end
    checks++; if (q_a.size() != 1 || q_a[0] !== 8'h85)
      begin failures++; $display("FAIL midrst_first got_count=%0d exp=1 byte 85", q_a.size()); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (wren_a !== 1'b0) begin failures++; $display("FAIL midrst_wren got=%b exp=0", wren_a); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_mon();
    repeat (80) @(negedge clk);
    checks++; if (q_a.size() != 0) begin failures++; $display("FAIL midrst_no_data got=%0d exp=0", q_a.size()); end
    checks++; if (idle_a !== 1'b1)  begin failures++; $display("FAIL midrst_idle got=%b exp=1", idle_a); end
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready_a); end
    checks++; if (wrdata_a !== 8'h00) begin failures++; $display("FAIL midrst_wrdata got=%h exp=00", wrdata_a); end
  endtask

  initial begin
    test_reset();
    test_freq();
    test_atten();
    test_noise();
    test_skip();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
